uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter between NREQ byte sources, each a FIFO with a show-ahead head and an empty flag.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ show-ahead byte FIFOs.
// A granted source may send up to BURST back-to-back bytes before the owner rotates.
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int DBIT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_empty,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_rd,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_data,
  input  logic                 tx_done_tick,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  logic [1:0]      state_reg, state_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [7:0]      burst_cnt_reg, burst_cnt_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [DBIT-1:0] tx_data_reg, tx_data_next;

  logic [DBIT-1:0] head [NREQ];
  logic [IW-1:0]   scan_idx [NREQ];
  logic [NREQ-1:0] scan_valid;
  logic            found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   owner_inc;

  // Slot gi of the scan looks at requester (rr_ptr + gi) mod NREQ.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IW:0] sum;
      assign head[gi]       = req_data[gi*DBIT +: DBIT];
      assign sum            = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
      assign scan_idx[gi]   = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
      assign scan_valid[gi] = ~req_empty[scan_idx[gi]];
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (scan_valid[k]) begin
        found    = 1'b1;
        pick_idx = scan_idx[k];
      end
    end
  end

  assign owner_inc = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    grant_next     = grant_reg;
    tx_data_next   = tx_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          state_next     = ST_ISSUE;
          owner_next     = pick_idx;
          grant_next     = NREQ'(1) << pick_idx;
          tx_data_next   = head[pick_idx];
          burst_cnt_next = '0;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_tick) begin
          // The head seen here is already the byte after the one just popped.
          if (burst_cnt_reg < BURST_LAST && !req_empty[owner_reg]) begin
            burst_cnt_next = burst_cnt_reg + 8'd1;
            tx_data_next   = head[owner_reg];
            state_next     = ST_ISSUE;
          end else begin
            rr_ptr_next = owner_inc;
            grant_next  = '0;
            state_next  = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      grant_reg     <= '0;
      tx_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      grant_reg     <= grant_next;
      tx_data_reg   <= tx_data_next;
    end
  end

  assign tx_start = (state_reg == ST_ISSUE);
  assign req_rd   = {NREQ{tx_start}} & grant_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign grant    = grant_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances (BURST 4, 2, 1) share FIFO and uart_tx models;
// sel routes the models to one instance at a time.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic [3:0] fifo_empty;
  logic [31:0] req_data;
  logic       done, manual_done, auto_done;

  logic [3:0] rd_a [3];
  logic       ts_a [3];
  logic [7:0] td_a [3];
  logic [3:0] gr_a [3];
  logic       bz_a [3];

  logic [3:0] req_rd_o, grant_o;
  logic       tx_start_o, busy_o;
  logic [7:0] tx_data_o;

  logic [7:0] mem [4][32];
  int wr_ptr [4];
  int rd_ptr [4];
  int uart_cnt;

  int errors, checks, cyc, log_n, rd_count;
  int         log_cyc   [32];
  logic [3:0] log_grant [32];
  logic [7:0] log_data  [32];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      uart_tx_arbiter #(
        .NREQ(4), .BURST((gi == 0) ? 4 : ((gi == 1) ? 2 : 1)), .DBIT(8)
      ) dut (
        .clk(clk),
        .reset(reset),
        .req_empty((sel == gi) ? fifo_empty : 4'hF),
        .req_data(req_data),
        .req_rd(rd_a[gi]),
        .tx_start(ts_a[gi]),
        .tx_data(td_a[gi]),
        .tx_done_tick((sel == gi) ? done : 1'b0),
        .grant(gr_a[gi]),
        .busy(bz_a[gi])
      );
    end
  endgenerate

  assign req_rd_o   = rd_a[sel];
  assign tx_start_o = ts_a[sel];
  assign tx_data_o  = td_a[sel];
  assign grant_o    = gr_a[sel];
  assign busy_o     = bz_a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead FIFO models
  always_comb begin
    fifo_empty = 4'hF;
    req_data   = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]     = (rd_ptr[i] == wr_ptr[i]);
      req_data[i*8 +: 8] = mem[i][rd_ptr[i] % 32];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (req_rd_o[i]) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  // uart_tx model: done pulse in the 4th cycle after the start pulse
  always @(posedge clk or posedge reset) begin
    if (reset)           uart_cnt <= 0;
    else if (tx_start_o) uart_cnt <= 4;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign auto_done = (uart_cnt == 1);
  assign done      = auto_done | manual_done;

  task automatic push(input int ch, input logic [7:0] b);
    mem[ch][wr_ptr[ch] % 32] = b;
    wr_ptr[ch] = wr_ptr[ch] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start_o) begin
      if (log_n < 32) begin
        log_cyc[log_n]   = cyc;
        log_grant[log_n] = grant_o;
        log_data[log_n]  = tx_data_o;
      end
      log_n++;
    end
    if (req_rd_o != 4'd0) rd_count++;
    if (tx_start_o || req_rd_o != 4'd0) begin
      checks++;
      if (!(tx_start_o && $onehot(req_rd_o))) begin
        errors++;
        $display("FAIL rd_pulse: tx_start=%0b req_rd=%b, required one-hot req_rd with tx_start", tx_start_o, req_rd_o);
      end
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy_o && n < 100) begin step(); n++; end
    checks++;
    if (busy_o) begin errors++; $display("FAIL idle_timeout: busy=%0b, required 0", busy_o); end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_o || fifo_empty != 4'hF) && n < 300) begin step(); n++; end
    checks++;
    if (busy_o || fifo_empty != 4'hF) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b empty=%b, required 0/1111", busy_o, fifo_empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 2'd0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gr_a[k], rd_a[k], ts_a[k], bz_a[k], td_a[k]} !== 18'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: grant=%b rd=%b start=%b busy=%b data=%h, required all 0",
                 k, gr_a[k], rd_a[k], ts_a[k], bz_a[k], td_a[k]);
      end
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    sel = 2'd0;
    log_n = 0;
    push(2, 8'hA5);
    step();
    checks++;
    if ({tx_start_o, grant_o, req_rd_o, tx_data_o, busy_o} !== {1'b1, 4'b0100, 4'b0100, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_issue: start=%b grant=%b rd=%b data=%h busy=%b, required 1 0100 0100 a5 1",
               tx_start_o, grant_o, req_rd_o, tx_data_o, busy_o);
    end
    step();
    checks++;
    if ({tx_start_o, grant_o, req_rd_o, busy_o} !== {1'b0, 4'b0100, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL single_wait: start=%b grant=%b rd=%b busy=%b, required 0 0100 0000 1",
               tx_start_o, grant_o, req_rd_o, busy_o);
    end
    wait_not_busy();
    checks++;
    if (grant_o !== 4'b0000 || log_n != 1) begin
      errors++;
      $display("FAIL single_end: grant=%b starts=%0d, required 0000 1", grant_o, log_n);
    end
    // rr_ptr must now be 3: FIFO3 beats FIFO0
    push(0, 8'h01);
    push(3, 8'h03);
    step();
    checks++;
    if ({tx_start_o, grant_o, tx_data_o} !== {1'b1, 4'b1000, 8'h03}) begin
      errors++;
      $display("FAIL rr_after_single: start=%b grant=%b data=%h, required 1 1000 03", tx_start_o, grant_o, tx_data_o);
    end
    wait_not_busy();
    step();
    checks++;
    if ({tx_start_o, grant_o, tx_data_o} !== {1'b1, 4'b0001, 8'h01}) begin
      errors++;
      $display("FAIL rr_wrap: start=%b grant=%b data=%h, required 1 0001 01", tx_start_o, grant_o, tx_data_o);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4];
    logic [3:0] exp_g [4];
    int n = 0;
    exp_d = '{8'h11, 8'h22, 8'h44, 8'h33};
    exp_g = '{4'b0010, 4'b0010, 4'b1000, 4'b0010};
    sel = 2'd1;
    log_n = 0;
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(3, 8'h44);
    while ((log_n < 4 || busy_o) && n < 200) begin step(); n++; end
    checks++;
    if (log_n != 4) begin errors++; $display("FAIL b2b_count: starts=%0d, required 4", log_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_data[k] !== exp_d[k] || log_grant[k] !== exp_g[k]) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: data=%h grant=%b, required %h %b", k, log_data[k], log_grant[k], exp_d[k], exp_g[k]);
      end
    end
    checks++;
    if (log_cyc[1] - log_cyc[0] != 5 || log_cyc[2] - log_cyc[1] != 6 || log_cyc[3] - log_cyc[2] != 6) begin
      errors++;
      $display("FAIL b2b_gaps: %0d %0d %0d, required 5 6 6",
               log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1], log_cyc[3] - log_cyc[2]);
    end
    drain();
  endtask

  task automatic test_burst1();
    int n = 0;
    sel = 2'd2;
    log_n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) push(i, 8'(i * 16 + j));
    while ((log_n < 8 || busy_o) && n < 300) begin step(); n++; end
    checks++;
    if (log_n != 8) begin errors++; $display("FAIL burst1_count: starts=%0d, required 8", log_n); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_grant[k] !== 4'(1 << (k % 4)) || log_data[k] !== 8'((k % 4) * 16 + k / 4)) begin
        errors++;
        $display("FAIL burst1_byte[%0d]: grant=%b data=%h, required %b %h",
                 k, log_grant[k], log_data[k], 4'(1 << (k % 4)), 8'((k % 4) * 16 + k / 4));
      end
      if (k > 0) begin
        checks++;
        if (log_cyc[k] - log_cyc[k-1] != 6) begin
          errors++;
          $display("FAIL burst1_gap[%0d]: %0d, required 6", k, log_cyc[k] - log_cyc[k-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_burst_end();
    int n = 0;
    sel = 2'd0;
    log_n = 0;
    rd_count = 0;
    push(0, 8'hB1); push(0, 8'hB2);
    while ((log_n < 2 || busy_o) && n < 100) begin step(); n++; end
    step(); step(); step();
    checks++;
    if (log_n != 2 || rd_count != 2 || grant_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: starts=%0d pops=%0d grant=%b busy=%b, required 2 2 0000 0", log_n, rd_count, grant_o, busy_o);
    end
    checks++;
    if (log_data[0] !== 8'hB1 || log_data[1] !== 8'hB2 || log_cyc[1] - log_cyc[0] != 5) begin
      errors++;
      $display("FAIL burst_end_bytes: %h %h gap=%0d, required b1 b2 5", log_data[0], log_data[1], log_cyc[1] - log_cyc[0]);
    end
    // rr_ptr must be 1: FIFO1 beats FIFO0
    push(0, 8'hC0); push(1, 8'hC1);
    step();
    checks++;
    if ({tx_start_o, grant_o, tx_data_o} !== {1'b1, 4'b0010, 8'hC1}) begin
      errors++;
      $display("FAIL rr_after_burst: start=%b grant=%b data=%h, required 1 0010 c1", tx_start_o, grant_o, tx_data_o);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    sel = 2'd0;
    push(0, 8'hD1); push(0, 8'hD2);
    step();
    checks++;
    if ({tx_start_o, grant_o, tx_data_o} !== {1'b1, 4'b0001, 8'hD1}) begin
      errors++;
      $display("FAIL rst_mid_issue: start=%b grant=%b data=%h, required 1 0001 d1", tx_start_o, grant_o, tx_data_o);
    end
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({grant_o, req_rd_o, tx_start_o, busy_o, tx_data_o} !== 18'd0) begin
      errors++;
      $display("FAIL rst_async: grant=%b rd=%b start=%b busy=%b data=%h, required all 0",
               grant_o, req_rd_o, tx_start_o, busy_o, tx_data_o);
    end
    step();
    checks++;
    if ({grant_o, req_rd_o, tx_start_o, busy_o, tx_data_o} !== 18'd0) begin
      errors++;
      $display("FAIL rst_held: grant=%b rd=%b start=%b busy=%b data=%h, required all 0",
               grant_o, req_rd_o, tx_start_o, busy_o, tx_data_o);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({tx_start_o, grant_o, tx_data_o} !== {1'b1, 4'b0001, 8'hD2}) begin
      errors++;
      $display("FAIL rst_regrant: start=%b grant=%b data=%h, required 1 0001 d2", tx_start_o, grant_o, tx_data_o);
    end
    drain();
  endtask

  task automatic test_done_ignored();
    int n = 0;
    sel = 2'd1;
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || tx_start_o !== 1'b0) begin
      errors++;
      $display("FAIL done_in_idle: busy=%b start=%b, required 0 0", busy_o, tx_start_o);
    end
    log_n = 0;
    push(2, 8'hE1); push(2, 8'hE2);
    step();
    checks++;
    if (tx_start_o !== 1'b1) begin errors++; $display("FAIL done_issue_start: start=%b, required 1", tx_start_o); end
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    checks++;
    if ({tx_start_o, busy_o, grant_o} !== {1'b0, 1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL done_in_issue: start=%b busy=%b grant=%b, required 0 1 0100", tx_start_o, busy_o, grant_o);
    end
    while ((log_n < 2 || busy_o) && n < 100) begin step(); n++; end
    checks++;
    if (log_n != 2 || log_data[0] !== 8'hE1 || log_data[1] !== 8'hE2 || log_cyc[1] - log_cyc[0] != 5) begin
      errors++;
      $display("FAIL done_issue_burst: starts=%0d %h %h gap=%0d, required 2 e1 e2 5",
               log_n, log_data[0], log_data[1], log_cyc[1] - log_cyc[0]);
    end
    drain();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; log_n = 0; rd_count = 0;
    manual_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_burst1();
    test_burst_end();
    test_reset_mid();
    test_done_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
